// File: rtl/gs_pkg.sv
// Shared constants, FSM state type and the 2 - D helper for the Goldschmidt controller.
package gs_pkg;

    localparam int          W        = 24;
    localparam int          FRAC     = 23;
    localparam logic [23:0] ONE      = 24'h800000;
    localparam logic [23:0] ERR_QUOT = 24'hFFFFFF;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        UPDATE,
        DONE
    } state_t;

    // Two's complement of a Q1.23 value equals 2 - d modulo 2^W.
    function automatic logic [W-1:0] two_minus(input logic [W-1:0] d);
        return ~d + W'(1);
    endfunction

endpackage

// File: rtl/gs_prod_trunc.sv
// Q2.46 product back to Q1.23; GS_ROUND_EN selects round-half-up with saturation, else truncation.
module gs_prod_trunc #(
    parameter int W = 24
) (
    input  logic [2*W-1:0] prod,
    output logic [W-1:0]   res
);
    import gs_pkg::*;

    // Bit 47 is always zero for in-range operands; low bits only feed rounding.
    logic unused_bits;
    assign unused_bits = ^{prod[2*W-1], prod[FRAC-1:0]};

`ifdef GS_ROUND_EN
    logic [W:0] sum;
    assign sum = {1'b0, prod[FRAC +: W]} + {{W{1'b0}}, prod[FRAC-1]};
    assign res = sum[W] ? {W{1'b1}} : sum[W-1:0];
`else
    assign res = prod[FRAC +: W];
`endif

endmodule

// File: rtl/gs_iter_ctrl.sv
// Goldschmidt iteration controller: drives two external pipelined multipliers ITER times.
// Optional build macro GS_ROUND_EN (in gs_prod_trunc) enables rounding of the products.
module gs_iter_ctrl #(
    parameter int W       = 24,
    parameter int MUL_LAT = 4,
    parameter int ITER    = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_n,
    input  logic [W-1:0]   in_d,
    output logic [W-1:0]   mul_n_a,
    output logic [W-1:0]   mul_n_x,
    output logic [W-1:0]   mul_d_a,
    output logic [W-1:0]   mul_d_x,
    input  logic [2*W-1:0] mul_n_p,
    input  logic [2*W-1:0] mul_d_p,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_quot,
    output logic           out_err
);
    import gs_pkg::*;

    localparam int              IT_W    = $clog2(ITER + 1);
    localparam int              WC_W    = $clog2(MUL_LAT + 1);
    localparam logic [IT_W-1:0] LAST_IT = IT_W'(ITER - 1);

    state_t          state;
    logic [W-1:0]    n_reg;
    logic [W-1:0]    d_reg;
    logic [IT_W-1:0] iter_cnt;
    logic [WC_W-1:0] wait_cnt;
    logic [W-1:0]    n_next;
    logic [W-1:0]    d_next;

    assign in_ready = (state == IDLE);

    gs_prod_trunc #(.W(W)) u_trunc_n (
        .prod (mul_n_p),
        .res  (n_next)
    );

    gs_prod_trunc #(.W(W)) u_trunc_d (
        .prod (mul_d_p),
        .res  (d_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            n_reg     <= '0;
            d_reg     <= '0;
            iter_cnt  <= '0;
            wait_cnt  <= '0;
            mul_n_a   <= '0;
            mul_n_x   <= '0;
            mul_d_a   <= '0;
            mul_d_x   <= '0;
            out_valid <= 1'b0;
            out_quot  <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Only D is range-checked; it must lie in [0.5,1).
                        if (in_d[W-1:W-2] == 2'b01) begin
                            n_reg    <= in_n;
                            d_reg    <= in_d;
                            iter_cnt <= '0;
                            state    <= ISSUE;
                        end else begin
                            out_quot  <= ERR_QUOT;
                            out_err   <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    mul_n_a  <= n_reg;
                    mul_n_x  <= two_minus(d_reg);
                    mul_d_a  <= d_reg;
                    mul_d_x  <= two_minus(d_reg);
                    wait_cnt <= WC_W'(MUL_LAT);
                    state    <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - WC_W'(1);
                    if (wait_cnt == WC_W'(1)) begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    n_reg    <= n_next;
                    d_reg    <= d_next;
                    iter_cnt <= iter_cnt + IT_W'(1);
                    if (iter_cnt == LAST_IT) begin
                        out_quot  <= n_next;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= ISSUE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gs_iter_ctrl.sv
// Bench for gs_iter_ctrl with two latency-MUL_LAT multiplier models; honours GS_ROUND_EN.
module tb_gs_iter_ctrl;

    localparam int W       = 24;
    localparam int MUL_LAT = 4;
    localparam int ITER    = 4;
    localparam int LAT     = ITER * (MUL_LAT + 2);
`ifdef GS_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_n = '0;
    logic [W-1:0]   in_d = '0;
    logic [W-1:0]   mul_n_a, mul_n_x, mul_d_a, mul_d_x;
    logic [2*W-1:0] mul_n_p, mul_d_p;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_quot;
    logic           out_err;

    gs_iter_ctrl #(.W(W), .MUL_LAT(MUL_LAT), .ITER(ITER)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_n      (in_n),
        .in_d      (in_d),
        .mul_n_a   (mul_n_a),
        .mul_n_x   (mul_n_x),
        .mul_d_a   (mul_d_a),
        .mul_d_x   (mul_d_x),
        .mul_n_p   (mul_n_p),
        .mul_d_p   (mul_d_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_quot  (out_quot),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // Free-running pipelined multipliers.
    logic [2*W-1:0] pipe_n [MUL_LAT];
    logic [2*W-1:0] pipe_d [MUL_LAT];
    always @(posedge clk) begin
        pipe_n[0] <= {{W{1'b0}}, mul_n_a} * {{W{1'b0}}, mul_n_x};
        pipe_d[0] <= {{W{1'b0}}, mul_d_a} * {{W{1'b0}}, mul_d_x};
        for (int i = 1; i < MUL_LAT; i++) begin
            pipe_n[i] <= pipe_n[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end
    assign mul_n_p = pipe_n[MUL_LAT-1];
    assign mul_d_p = pipe_d[MUL_LAT-1];

    typedef struct {
        logic [W-1:0] n;
        logic [W-1:0] d;
        logic [W-1:0] q;
        logic         err;
        int           lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic         err;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    exp_t sbq[$];
    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] slice(input logic [2*W-1:0] p, input bit rnd);
        logic [W:0] s;
        if (!rnd) return p[46:23];
        s = {1'b0, p[46:23]} + {{W{1'b0}}, p[22]};
        return s[W] ? {W{1'b1}} : s[W-1:0];
    endfunction

    function automatic logic [W-1:0] model(input logic [W-1:0] n0, input logic [W-1:0] d0,
                                           input bit rnd);
        logic [W-1:0]   n, d, f;
        logic [2*W-1:0] pn, pd;
        n = n0;
        d = d0;
        for (int k = 0; k < ITER; k++) begin
            f  = ~d + 24'd1;
            pn = {{W{1'b0}}, n} * {{W{1'b0}}, f};
            pd = {{W{1'b0}}, d} * {{W{1'b0}}, f};
            n  = slice(pn, rnd);
            d  = slice(pd, rnd);
        end
        return n;
    endfunction

    function automatic vec_t mkvec(input logic [W-1:0] n, input logic [W-1:0] d);
        vec_t v;
        v.n = n;
        v.d = d;
        if (d[23:22] == 2'b01) begin
            v.q = model(n, d, RND);  v.err = 1'b0;  v.lat = LAT;
        end else begin
            v.q = 24'hFFFFFF;        v.err = 1'b1;  v.lat = 1;
        end
        return v;
    endfunction

    task automatic send(input vec_t v);
        exp_t e;
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        in_n     = v.n;
        in_d     = v.d;
        e.q      = v.q;
        e.err    = v.err;
        sbq.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(input int exp_lat);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (cyc < 200) begin
            @(posedge clk);
            #1 cyc++;
            if (out_valid) break;
        end
        check("out_valid_seen", 64'(out_valid), 64'(1));
        check("latency", 64'(cyc), 64'(exp_lat));
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check("out_quot", 64'(out_quot), 64'(e.q));
            check("out_err", 64'(out_err), 64'(e.err));
        end else begin
            check("scoreboard_nonempty", 64'(sbq.size()), 64'(1));
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("out_valid_cleared", 64'(out_valid), 64'(0));
        check("in_ready_back", 64'(in_ready), 64'(1));
    endtask

    task automatic run_div(input vec_t v);
        send(v);
        wait_out(v.lat);
        release_out();
    endtask

    logic [W-1:0] f_trace [4] = '{24'hC00000, 24'hA00000, 24'h880000, 24'h808000};
    logic [W-1:0] d_trace [4] = '{24'h400000, 24'h600000, 24'h780000, 24'h7F8000};

    initial begin
        vec_t v;
        exp_t e;
        int   diff;

        // Table: spec vectors with hand-derived results, range errors, model-checked vectors.
        tbl.push_back('{24'h400000, 24'h400000, 24'h7FFF80, 1'b0, LAT});
        tbl.push_back('{24'h600000, 24'h400000, 24'hBFFF40, 1'b0, LAT});
        tbl.push_back('{24'h400000, 24'h800000, 24'hFFFFFF, 1'b1, 1});
        tbl.push_back('{24'h400000, 24'h3FFFFF, 24'hFFFFFF, 1'b1, 1});
        tbl.push_back('{24'h7FFFFF, 24'hC00000, 24'hFFFFFF, 1'b1, 1});
        tbl.push_back(mkvec(24'h555555, 24'h7FFFFF));
        tbl.push_back(mkvec(24'h7FFFFF, 24'h400001));
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(mkvec({2'b01, 22'($urandom)}, {2'b01, 22'($urandom)}));
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_quot", 64'(out_quot), 64'(0));
        check("rst_out_err", 64'(out_err), 64'(0));
        check("rst_mul_n_a", 64'(mul_n_a), 64'(0));
        @(negedge clk) rst_n = 1'b1;

        // Error path leaves multiplier operands untouched.
        run_div('{24'h400000, 24'h800000, 24'hFFFFFF, 1'b1, 1});
        check("err_mul_ops", 64'({mul_n_a, mul_n_x}), 64'(0));
        check("err_mul_ops_d", 64'({mul_d_a, mul_d_x}), 64'(0));

        for (int i = 0; i < tbl.size(); i++) begin
            run_div(tbl[i]);
        end

        // Operand trace per iteration.
        send('{24'h600000, 24'h400000, 24'hBFFF40, 1'b0, LAT});
        for (int k = 0; k < ITER; k++) begin
            @(posedge clk);
            #1;
            check("trace_f", 64'(mul_d_x), 64'(f_trace[k]));
            check("trace_n_f", 64'(mul_n_x), 64'(f_trace[k]));
            check("trace_d", 64'(mul_d_a), 64'(d_trace[k]));
            repeat (MUL_LAT + 1) @(posedge clk);
        end
        #1;
        check("trace_valid", 64'(out_valid), 64'(1));
        e = sbq.pop_front();
        check("trace_quot", 64'(out_quot), 64'(e.q));
        release_out();

        // Backpressure: DONE holds its result while new requests are ignored.
        send('{24'h400000, 24'h400000, 24'h7FFF80, 1'b0, LAT});
        wait_out(LAT);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_n     = 24'h600000;
            in_d     = 24'h600000;
            @(posedge clk);
            #1;
            check("bp_valid", 64'(out_valid), 64'(1));
            check("bp_quot", 64'(out_quot), 64'(24'h7FFF80));
            check("bp_in_ready", 64'(in_ready), 64'(0));
        end
        in_valid = 1'b0;
        release_out();
        run_div('{24'h600000, 24'h400000, 24'hBFFF40, 1'b0, LAT});

        // Asynchronous reset during the third WAIT discards the division.
        send('{24'h400000, 24'h400000, 24'h7FFF80, 1'b0, LAT});
        repeat (14) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        check("midrst_mul_n_a", 64'(mul_n_a), 64'(0));
        void'(sbq.pop_front());
        @(negedge clk) rst_n = 1'b1;
        run_div('{24'h600000, 24'h400000, 24'hBFFF40, 1'b0, LAT});

        // Rounded and truncated results stay within one LSB of each other.
        v = mkvec(24'h555555, 24'h7FFFFF);
        run_div(v);
        diff = int'(out_quot) - int'(model(24'h555555, 24'h7FFFFF, 1'b0));
        check("round_vs_trunc", 64'((diff <= 1) && (diff >= -1)), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
